// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host push handshake and serial line status for uart_tx_fifo
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic                 tx_start;
   logic [DATA_BITS-1:0] tx_byte;
   logic                 tx_ready;
   logic                 tx_sending;
   logic                 tx_done;
   logic                 tx_output;

   // Host side: pushes words and observes the line
   modport master (
      output tx_start, tx_byte,
      input  tx_ready, tx_sending, tx_done, tx_output
   );

   // Transmitter side
   modport slave (
      input  tx_start, tx_byte,
      output tx_ready, tx_sending, tx_done, tx_output
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with configurable baud, width, parity and stop bits
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_fifo_if.slave   bus
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q;

   state_t               state_q, state_d;
   logic [BW-1:0]        baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 line_q, line_d;
   logic                 done_q, done_d;

   logic                 push, pop;
   logic                 fifo_empty;
   logic                 baud_last;
   logic [DATA_BITS-1:0] head;
   logic                 head_par;

   assign bus.tx_ready   = (count_q != FULL);
   assign bus.tx_sending = (state_q != ST_IDLE);
   assign bus.tx_done    = done_q;
   assign bus.tx_output  = line_q;

   assign push       = bus.tx_start && bus.tx_ready;
   assign fifo_empty = (count_q == '0);
   assign baud_last  = (baud_q == BAUD_LAST);
   assign head       = mem_q[rd_ptr_q];
   // Odd parity is the inverse of the XOR of the data bits; even (and unused none) is the XOR
   assign head_par   = (PARITY == 1) ? ~(^head) : (^head);

   // FIFO storage: only written on an accepted push, so it needs no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.tx_byte;
      end
   end

   // FIFO pointers wrap modulo depth; a simultaneous push and pop leaves the count alone
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Frame state, counters and the registered line/done outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         line_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         line_q  <= line_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; line and done are derived from the next state so they register in step with it
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               par_d   = head_par;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         ST_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         ST_PARITY: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_STOP;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         ST_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  // Chain straight into the next frame when a word is waiting
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     shift_d = head;
                     par_d   = head_par;
                     state_d = ST_START;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      case (state_d)
         ST_START:  line_d = 1'b0;
         ST_DATA:   line_d = shift_d[0];
         ST_PARITY: line_d = par_d;
         default:   line_d = 1'b1;
      endcase

      done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   uart_tx_fifo_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_fifo_if #(.DATA_BITS(7)) bus1 ();
   uart_tx_fifo_if #(.DATA_BITS(7)) bus2 ();

   uart_tx_fifo u0 (.clk(clk), .rst(rst), .bus(bus0));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
      u1 (.clk(clk), .rst(rst), .bus(bus1));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
      u2 (.clk(clk), .rst(rst), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pushes n words on consecutive edges; from an empty idle FIFO ready drops only before the 6th
   task automatic push_burst0(input int n, input logic [7:0] first, input logic [7:0] step);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         chk("ready_push", {31'd0, bus0.tx_ready}, {31'd0, (i < 5)});
         bus0.tx_start = 1'b1;
         bus0.tx_byte  = first + 8'(i) * step;
         @(negedge clk);
      end
      bus0.tx_start = 1'b0;
   endtask

   // Checks cycles kstart..kend of an 8N1 frame of w at 16 clocks/bit; optional push on its last cycle
   task automatic frame0(input logic [7:0] w, input int kstart, input int kend,
                         input bit push_end, input logic [7:0] pw);
      logic el;
      for (int k = kstart; k <= kend; k++) begin
         @(negedge clk);
         if (k <= 16)       el = 1'b0;
         else if (k <= 144) el = w[(k - 17) / 16];
         else               el = 1'b1;
         chk($sformatf("f0_%0h_k%0d", w, k),
             {29'd0, bus0.tx_output, bus0.tx_done, bus0.tx_sending},
             {29'd0, el, (k == 160), 1'b1});
         if (push_end && k == 160) begin
            bus0.tx_start = 1'b1;
            bus0.tx_byte  = pw;
            @(posedge clk);
            #1;
            bus0.tx_start = 1'b0;
            chk("ready_pushpop", {31'd0, bus0.tx_ready}, 32'd1);
         end
      end
   endtask

   task automatic idle0(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("idle0", {29'd0, bus0.tx_output, bus0.tx_done, bus0.tx_sending}, 32'b100);
      end
   endtask

   // 4 clocks/bit, 7 data bits, parity, 2 stop bits: 44-cycle frame on u1 (even) and u2 (odd)
   task automatic frame_s(input logic [6:0] w, input logic pe, input logic po, input int kstart);
      logic l1, l2;
      for (int k = kstart; k <= 44; k++) begin
         @(negedge clk);
         if (k <= 4)       begin l1 = 1'b0; l2 = 1'b0; end
         else if (k <= 32) begin l1 = w[(k - 5) / 4]; l2 = l1; end
         else if (k <= 36) begin l1 = pe; l2 = po; end
         else              begin l1 = 1'b1; l2 = 1'b1; end
         chk($sformatf("f1_%0h_k%0d", w, k),
             {29'd0, bus1.tx_output, bus1.tx_done, bus1.tx_sending}, {29'd0, l1, (k == 44), 1'b1});
         chk($sformatf("f2_%0h_k%0d", w, k),
             {29'd0, bus2.tx_output, bus2.tx_done, bus2.tx_sending}, {29'd0, l2, (k == 44), 1'b1});
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus0.tx_start = 1'b0; bus0.tx_byte = '0;
      bus1.tx_start = 1'b0; bus1.tx_byte = '0;
      bus2.tx_start = 1'b0; bus2.tx_byte = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state: {line, done, sending, ready} = 1,0,0,1
      @(negedge clk);
      chk("rst_u0", {28'd0, bus0.tx_output, bus0.tx_done, bus0.tx_sending, bus0.tx_ready}, 32'b1001);
      chk("rst_u1", {28'd0, bus1.tx_output, bus1.tx_done, bus1.tx_sending, bus1.tx_ready}, 32'b1001);
      chk("rst_u2", {28'd0, bus2.tx_output, bus2.tx_done, bus2.tx_sending, bus2.tx_ready}, 32'b1001);

      // Parity configs: 0x55 has four ones (even 0, odd 1); 0x07 has three (even 1, odd 0)
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         bus1.tx_start = 1'b1; bus1.tx_byte = (i == 0) ? 7'h55 : 7'h07;
         bus2.tx_start = 1'b1; bus2.tx_byte = (i == 0) ? 7'h55 : 7'h07;
         @(negedge clk);
      end
      bus1.tx_start = 1'b0;
      bus2.tx_start = 1'b0;
      frame_s(7'h55, 1'b0, 1'b1, 2);
      frame_s(7'h07, 1'b1, 1'b0, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("idle1", {30'd0, bus1.tx_output, bus1.tx_sending}, 32'b10);
         chk("idle2", {30'd0, bus2.tx_output, bus2.tx_sending}, 32'b10);
      end

      // Single 8N1 frame of 0xA5
      push_burst0(1, 8'hA5, 8'h00);
      frame0(8'hA5, 1, 160, 1'b0, 8'h00);
      idle0(5);

      // Six pushes into depth 4: 0x01..0x05 emitted back-to-back, 0x06 dropped
      push_burst0(6, 8'h01, 8'h01);
      frame0(8'h01, 6, 160, 1'b0, 8'h00);
      for (int i = 2; i <= 5; i++) frame0(8'(i), 1, 160, 1'b0, 8'h00);
      idle0(30);

      // Count 3 with a push on the end-of-stop pop edge
      push_burst0(4, 8'h11, 8'h11);
      frame0(8'h11, 4, 160, 1'b1, 8'h99);
      frame0(8'h22, 1, 160, 1'b0, 8'h00);
      frame0(8'h33, 1, 160, 1'b0, 8'h00);
      frame0(8'h44, 1, 160, 1'b0, 8'h00);
      frame0(8'h99, 1, 160, 1'b0, 8'h00);
      idle0(5);

      // Reset during data bit 3 with two words queued
      push_burst0(3, 8'hC3, 8'h01);
      frame0(8'hC3, 3, 70, 1'b0, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid", {28'd0, bus0.tx_output, bus0.tx_done, bus0.tx_sending, bus0.tx_ready}, 32'b1001);
      idle0(200);

      // Wrap-around: 13 distinct words in bursts of 5, 5, 3
      push_burst0(5, 8'h40, 8'h01);
      frame0(8'h40, 5, 160, 1'b0, 8'h00);
      for (int i = 1; i < 5; i++) frame0(8'h40 + 8'(i), 1, 160, 1'b0, 8'h00);
      idle0(3);
      push_burst0(5, 8'h45, 8'h01);
      frame0(8'h45, 5, 160, 1'b0, 8'h00);
      for (int i = 1; i < 5; i++) frame0(8'h45 + 8'(i), 1, 160, 1'b0, 8'h00);
      idle0(3);
      push_burst0(3, 8'h4A, 8'h01);
      frame0(8'h4A, 3, 160, 1'b0, 8'h00);
      frame0(8'h4B, 1, 160, 1'b0, 8'h00);
      frame0(8'h4C, 1, 160, 1'b0, 8'h00);
      idle0(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
